// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial WIDTH-bit subtractor (diff = a - b), LSB first,
// one bit per clock, with a start/busy/done handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a subtraction (sampled in IDLE or DONE only)
//   a, b       minuend / subtrahend, captured on the accepting edge
//   busy       high while the bit loop runs
//   done       one-cycle pulse, diff/borrow_out hold a fresh result
//   diff       (a - b) mod 2^WIDTH, held until the next result
//   borrow_out final borrow, 1 iff a < b (unsigned)
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic             bin;
    logic [CW-1:0]    cnt;

    logic d1, br1, d_i, br2, bout;
    logic accept;
    logic last;

    // 1-bit half subtractor: returns {borrow, difference} of x - y.
    function automatic logic [1:0] half_sub(input logic x, input logic y);
        return {~x & y, x ^ y};
    endfunction

    // Full-subtract cell: two half subtractors plus an OR for the borrow.
    always_comb begin
        {br1, d1} = half_sub(sa[0], sb[0]);
        {br2, d_i} = half_sub(d1, bin);
        bout = br1 | br2;
    end

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last) state_n = DONE;
            DONE:    state_n = start ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // busy/done are flopped from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n == RUN);
            done  <= (state_n == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa         <= '0;
            sb         <= '0;
            sd         <= '0;
            bin        <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            bin <= 1'b0;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= {1'b0, sa[WIDTH-1:1]};
            sb  <= {1'b0, sb[WIDTH-1:1]};
            sd  <= {d_i, sd[WIDTH-1:1]};
            bin <= bout;
            cnt <= cnt + 1'b1;
            // The last bit goes straight into diff alongside the shifted sd.
            if (last) begin
                diff       <= {d_i, sd[WIDTH-1:1]};
                borrow_out <= bout;
            end
        end
    end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial multi-bit subtraction controller. It computes the WIDTH-bit difference `a - b` one bit per clock, LSB first. Each bit is computed by a full-subtract cell built from two instances of the team's 1-bit half subtractor plus an OR gate. The controller owns the operand shift registers, the borrow flop, the bit counter and a start/done handshake. It is the sequencer that lets one 1-bit subtract datapath serve WIDTH-bit operands in the arithmetic section of the design.

## Interface

- WIDTH, 8, operand and result width in bits; legal range 2..32.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a subtraction; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend, captured on the accepting edge.
- b  input  WIDTH  subtrahend, captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: result valid.
- diff  output  WIDTH  result register, `(a - b) mod 2^WIDTH`.
- borrow_out  output  1  final borrow; 1 iff a < b (unsigned).

## Operation

- Per-bit cell:
  - Half subtractor 1: (a_i, b_i) gives d1 and br1.
  - Half subtractor 2: (d1, bin) gives d_i and br2.
  - bout = br1 | br2.
- States: IDLE, RUN, DONE; 2-bit state register.
- IDLE:
  - On start=1: load sa←a, sb←b, bin←0, cnt←0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - d_i and bout come from sa[0], sb[0] and bin.
  - Shift sa and sb right by 1.
  - Shift d_i into the MSB of the internal shift register sd (right shift).
  - bin←bout; cnt←cnt+1.
  - When cnt == WIDTH-1 on that edge, go to DONE and load diff from the final sd contents (including this edge's bit). Load borrow_out←bout.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 is accepted exactly as in IDLE: go to RUN, back-to-back.
  - Otherwise go to IDLE.
- start in RUN is ignored; it is neither queued nor an abort.
- The a and b inputs are don't-care except on the accepting edge.
- diff and borrow_out change only on the RUN→DONE edge. They hold the last result through IDLE and through any subsequent RUN.
- cnt is $clog2(WIDTH) bits and never wraps within an operation. It is reloaded to 0 on every accepting edge.
- Reset (rst_n low, asynchronous, at any time including mid-RUN):
  - state←IDLE.
  - busy=0, done=0, diff=0, borrow_out=0.
  - sa, sb, sd, bin, cnt all cleared.
  - A partial operation is discarded and no done is produced.

## Timing

- Accepting edge E0 (start=1 in IDLE or DONE): busy=1 from E0 until edge E0+WIDTH.
- Bits 0..WIDTH-1 are processed on edges E0+1 .. E0+WIDTH.
- done=1 and the new diff/borrow_out are valid in the cycle after edge E0+WIDTH. Latency is WIDTH+1 edges from start to done falling.
- Throughput: one result per WIDTH+1 cycles with start held high continuously.
- busy and done are registered and never both high.
- done is never high for two consecutive cycles.
- Reset release: first accepting edge is the first rising edge with rst_n high and start=1.

## Test plan

- WIDTH=8, a=100, b=37, single start pulse → busy high 8 cycles; then done pulse, diff=63, borrow_out=0, done on the 8th edge after the accepting edge.
- a=5, b=9 → diff=252 (0xFC), borrow_out=1. Then a=0xFF, b=0x00 → diff=0xFF, borrow_out=0. Then a=0, b=0 → diff=0, borrow_out=0.
- start held high with a=50, b=20, then a=3, b=4 → second operation accepted in the DONE cycle, no IDLE gap; diffs 30 then 255 with borrow_out 0 then 1; done pulses exactly 9 cycles apart.
- start pulsed with a=10, b=3; start re-pulsed at cycle 4 of RUN with a=1, b=2 → ignored; result diff=7, borrow_out=0; only one done.
- rst_n driven low at cycle 3 of RUN (a=200, b=100) → all outputs 0 immediately, asynchronously; no done after release; a new start with a=200, b=100 gives diff=100.
- Exhaustive random check, WIDTH=4, all 256 operand pairs → diff == (a-b) & 0xF and borrow_out == (a<b) for every pair.
